demux_1_8_tdm: RTL and testbench

- Receive-side counterpart of the 8:1 selector path.
- Takes a time-division serial stream (one bit per slot, slot 0..7, as produced by an 8:1 mux swept by a 3-bit select counter) and rebuilds the 8-bit code word.
- Presents the word as a registered parallel word with a one-cycle valid strobe.
- Tracks slot position, detects broken frames and stalled frames.

---
 rtl/demux_1_8_tdm.sv | 159 +++++++++++++++
 tb/tb_demux_1_8_tdm.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_8_tdm.sv
// Receive side of the 8:1 time-division selector path.
// Collects one serial bit per slot into an 8-bit word and flags broken or stalled frames.
module demux_1_8_tdm #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_valid,
  input  logic       i_frame_start,
  input  logic       i_d,
  output logic [2:0] o_sel_code,
  output logic [7:0] o_code,
  output logic       o_code_valid,
  output logic       o_busy,
  output logic       o_frame_err
);

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned CODE_W  = 8;
  localparam int unsigned SHDW_W  = CODE_W - 1;
  localparam int unsigned TMO_W   = 8;
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_MAX   = {TMO_W{1'b1}};
  localparam logic [SEL_W-1:0]  LAST_SLOT = SEL_W'(CODE_W - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [SHDW_W-1:0]   shadow_q;
  logic [SHDW_W-1:0]   shadow_d;
  logic [TMO_W-1:0]    tmo_q;
  logic [TMO_W-1:0]    tmo_d;
  logic [SEL_W-1:0]    sel_d;
  logic [CODE_W-1:0]   code_d;
  logic                code_valid_d;
  logic                frame_err_d;

  logic                beat_c;
  logic                last_beat_c;
  logic [TMO_W-1:0]    tmo_inc_c;
  logic                tmo_hit_c;

  assign beat_c      = i_en & i_valid;
  assign last_beat_c = (o_sel_code == LAST_SLOT);
  // Saturating increment so the counter can never wrap back below the limit
  assign tmo_inc_c   = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
  assign tmo_hit_c   = (tmo_inc_c >= TMO_LIMIT);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (beat_c && i_frame_start) begin
          state_d = S_RECV;
        end
      end
      S_RECV: begin
        if (beat_c) begin
          if (!i_frame_start && last_beat_c) begin
            state_d = S_IDLE;
          end
        end else if (i_en && tmo_hit_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for the datapath and registered outputs
  always_comb begin
    sel_d        = o_sel_code;
    shadow_d     = shadow_q;
    tmo_d        = tmo_q;
    code_d       = o_code;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (beat_c && i_frame_start) begin
          shadow_d = {{(SHDW_W-1){1'b0}}, i_d};
          sel_d    = SEL_W'(1);
        end
      end
      S_RECV: begin
        if (beat_c) begin
          tmo_d = '0;
          if (i_frame_start) begin
            // Premature restart: drop the partial word, this beat is slot 0
            frame_err_d = 1'b1;
            shadow_d    = {{(SHDW_W-1){1'b0}}, i_d};
            sel_d       = SEL_W'(1);
          end else begin
            for (int unsigned k = 0; k < SHDW_W; k++) begin
              if (o_sel_code == SEL_W'(k)) begin
                shadow_d[k] = i_d;
              end
            end
            sel_d = o_sel_code + SEL_W'(1);
            if (last_beat_c) begin
              code_d       = {i_d, shadow_q};
              code_valid_d = 1'b1;
            end
          end
        end else if (i_en) begin
          if (tmo_hit_c) begin
            frame_err_d = 1'b1;
            sel_d       = '0;
            tmo_d       = '0;
          end else begin
            tmo_d = tmo_inc_c;
          end
        end
      end
      default: begin
        sel_d = '0;
        tmo_d = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sel_code   <= '0;
      shadow_q     <= '0;
      tmo_q        <= '0;
      o_code       <= '0;
      o_code_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_sel_code   <= sel_d;
      shadow_q     <= shadow_d;
      tmo_q        <= tmo_d;
      o_code       <= code_d;
      o_code_valid <= code_valid_d;
      o_busy       <= (state_d == S_RECV);
      o_frame_err  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_demux_1_8_tdm.sv
// Bench for demux_1_8_tdm: hand-computed vector table, directed frame sequences
// and randomized traffic checked against a queue-based frame model.
module tb_demux_1_8_tdm;

  localparam int unsigned TMO = 16;

  logic       clk = 1'b0;
  logic       rst, en, valid, fs, d;
  logic [2:0] sel_code;
  logic [7:0] code;
  logic       code_valid, busy, frame_err;

  demux_1_8_tdm #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_valid      (valid),
    .i_frame_start(fs),
    .i_d          (d),
    .o_sel_code   (sel_code),
    .o_code       (code),
    .o_code_valid (code_valid),
    .o_busy       (busy),
    .o_frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_no   = 0;
  int err_pulses = 0;
  int cv_cycles[$];

  // Reference model: a frame is the list of bits collected so far
  bit         m_q[$];
  int         m_idle = 0;
  logic [2:0] e_sel  = '0;
  logic [7:0] e_code = '0;
  logic       e_cv = 1'b0, e_busy = 1'b0, e_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_no, act, exp);
    end
  endtask

  task automatic model(input logic r, input logic e, input logic v, input logic f, input logic dd);
    e_cv  = 1'b0;
    e_err = 1'b0;
    if (r) begin
      m_q.delete();
      m_idle = 0;
      e_code = '0;
    end else if (e && v) begin
      m_idle = 0;
      if (f) begin
        if (m_q.size() != 0) e_err = 1'b1;
        m_q.delete();
        m_q.push_back(dd);
      end else if (m_q.size() != 0) begin
        m_q.push_back(dd);
        if (m_q.size() == 8) begin
          e_code = '0;
          for (int k = 0; k < 8; k++) e_code[k] = m_q[k];
          e_cv = 1'b1;
          m_q.delete();
        end
      end
    end else if (e && m_q.size() != 0) begin
      m_idle++;
      if (m_idle == int'(TMO)) begin
        e_err = 1'b1;
        m_q.delete();
        m_idle = 0;
      end
    end
    e_busy = (m_q.size() != 0);
    e_sel  = 3'(m_q.size());
  endtask

  task automatic step(input logic r, input logic e, input logic v, input logic f, input logic dd);
    rst = r; en = e; valid = v; fs = f; d = dd;
    model(r, e, v, f, dd);
    @(posedge clk);
    #1;
    cyc_no++;
    check("sel_code",   32'(sel_code),   32'(e_sel));
    check("code",       32'(code),       32'(e_code));
    check("code_valid", 32'(code_valid), 32'(e_cv));
    check("busy",       32'(busy),       32'(e_busy));
    check("frame_err",  32'(frame_err),  32'(e_err));
    if (code_valid === 1'b1) cv_cycles.push_back(cyc_no);
    if (frame_err === 1'b1) err_pulses++;
  endtask

  task automatic send_frame(input logic [7:0] w);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b1, k == 0, w[k]);
  endtask

  typedef struct {
    logic       r, e, v, f, d;
    logic [2:0] sel;
    logic [7:0] code;
    logic       cv, busy, err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; fs = 1'b0; d = 1'b0;

    // Reset then frame 8'h4D (slot bits 1,0,1,1,0,0,1,0), values after each edge
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h4D, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h4D, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].f, tbl[i].d);
      check("tbl_sel",  32'(sel_code),   32'(tbl[i].sel));
      check("tbl_code", 32'(code),       32'(tbl[i].code));
      check("tbl_cv",   32'(code_valid), 32'(tbl[i].cv));
      check("tbl_busy", 32'(busy),       32'(tbl[i].busy));
      check("tbl_err",  32'(frame_err),  32'(tbl[i].err));
    end

    // Back-to-back frames with no idle cycle
    err_pulses = 0;
    cv_cycles.delete();
    send_frame(8'hA5);
    check("b2b_first_code", 32'(code), 32'h0000_00A5);
    send_frame(8'h3C);
    check("b2b_second_code", 32'(code), 32'h0000_003C);
    check("b2b_pulse_count", 32'(cv_cycles.size()), 32'd2);
    if (cv_cycles.size() == 2)
      check("b2b_pulse_spacing", 32'(cv_cycles[1] - cv_cycles[0]), 32'd8);
    check("b2b_no_err", 32'(err_pulses), 32'd0);

    // Frame 8'hFF restarted at slot 4, then a clean 8'h0F
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    err_pulses = 0;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, k == 0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b1, k == 0, (k < 4) ? 1'b1 : 1'b0);
      if (k < 7) check("restart_code_held", 32'(code), 32'h0);
    end
    check("restart_code", 32'(code), 32'h0000_000F);
    check("restart_err_count", 32'(err_pulses), 32'd1);

    // Stall at slot 5 with enable low for 40 cycles, frame 8'hC3
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    err_pulses = 0;
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, k == 0, ((8'hC3 >> k) & 8'h01) != 0);
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      check("stall_sel_frozen", 32'(sel_code), 32'd5);
    end
    for (int k = 5; k < 8; k++) step(1'b0, 1'b1, 1'b1, 1'b0, ((8'hC3 >> k) & 8'h01) != 0);
    check("stall_code", 32'(code), 32'h0000_00C3);
    check("stall_no_err", 32'(err_pulses), 32'd0);

    // Timeout after 3 beats: abort pulse appears after the 16th empty cycle
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("tmo_err", 32'(frame_err), (i == 16) ? 32'd1 : 32'd0);
    end
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_sel", 32'(sel_code), 32'd0);
    check("tmo_code", 32'(code), 32'h0000_00C3);

    // Reset at slot 6 mid-frame, then stray beats without frame_start
    cv_cycles.delete();
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b1, k == 0, 1'b1);
    check("pre_rst_sel", 32'(sel_code), 32'd6);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_sel", 32'(sel_code), 32'd0);
    check("rst_code", 32'(code), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_stray_ignored", 32'(busy), 32'd0);
    check("rst_no_valid", 32'(cv_cycles.size()), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
